phase_slot_arbiter: RTL and testbench
=====================================

// Module: phase_slot_arbiter
// PURPOSE
//   Fast-domain round-robin arbiter sharing one slow-domain transfer slot among N_REQ requesters.
//   Consumes the phase count (cnt) from the clock phase counter and monitors it for slips.
//   Launches at most one transaction per slow period, at a fixed fast-clock phase (LAUNCH_PHASE).
//   Holds the granted word stable for RATIO fast cycles so the slow domain samples it safely.
// PARAMETERS
//   RATIO        4         fast cycles per slow period; >= 2
//   N_REQ        4         number of requesters; >= 2
//   DATA_W       64        payload width per requester
//   LAUNCH_PHASE 0         cnt value on which arbitration occurs; < RATIO
//   LOCK_CYCLES  2*RATIO   consecutive well-formed cnt steps required to lock; >= 1
// PORTS
//   clk_fast  in   1                     single clock (fast domain)
//   rst       in   1                     synchronous, active-high reset
//   cnt       in   $clog2(RATIO)         phase count, fast domain
//   req       in   N_REQ                 request per requester, level
//   req_data  in   N_REQ*DATA_W          payload; requester i at [i*DATA_W +: DATA_W]
//   gnt       out  N_REQ                 one-hot grant, 1-cycle pulse
//   out_valid out  1                     slot holds a valid transaction
//   out_data  out  DATA_W                granted payload, stable while out_valid
//   out_id    out  max(1,$clog2(N_REQ))  index of granted requester
//   locked    out  1                     phase tracking locked
//   err_slip  out  1                     1-cycle pulse on phase slip while locked
// BEHAVIOUR
//   Reset: gnt=0, out_valid=0, out_data=0, out_id=0, locked=0, err_slip=0.
//     State: FSM=UNLOCKED, good_cnt=0, prev_valid=0, rr_ptr=N_REQ-1, so requester 0 wins first.
//   Well-formed step (requires prev_valid=1):
//     (prev==RATIO-1 && cnt==0) || (prev<RATIO-1 && cnt==prev+1).
//     prev is cnt registered each cycle. prev_valid sets on the first cycle after reset.
//     Any cnt >= RATIO is malformed.
//   FSM UNLOCKED:
//     Well-formed step: good_cnt++. Otherwise good_cnt=0.
//     When the step is well-formed and good_cnt==LOCK_CYCLES-1: go to LOCKED; locked=1 next cycle.
//     No grants are issued while UNLOCKED.
//   FSM LOCKED:
//     Malformed step: go to UNLOCKED, good_cnt=0.
//     Next cycle: err_slip=1 (one cycle), locked=0, out_valid=0; out_data/out_id hold their values.
//     A transaction granted before the slip is dropped. Upstream recovers using err_slip.
//   Arbitration (LOCKED, cnt==LAUNCH_PHASE, step well-formed, |req):
//     Winner k = first set req at or after index rr_ptr+1, searching mod N_REQ.
//     req_data sampled this cycle (T).
//     At T+1: gnt[k]=1 for one cycle, out_data=slice k, out_id=k, out_valid=1, rr_ptr=k.
//   Empty launch (LOCKED, cnt==LAUNCH_PHASE, req==0):
//     At T+1: out_valid=0; rr_ptr, out_data and out_id unchanged.
//   Slot hold:
//     out_* change only at T+1 of a launch cycle, or on slip or reset.
//     Consecutive grants give continuous out_valid with a new word every RATIO cycles.
//   Handshake:
//     Requester holds req and req_data stable until it sees gnt. It may drop req at T+1.
//     cnt!=LAUNCH_PHASE at T+1 (RATIO>=2), so no double grant is possible.
//   Simultaneous slip and launch phase: slip wins, no grant.
//   Reset mid-operation: all state returns to reset values next cycle; relock restarts from zero.
// TESTING
//   T1 lock: rst released, cnt=0,1,2,3,0,... from the first cycle
//     -> locked=1 on cycle 9; no gnt before that cycle.
//   T2 round robin: locked, req=4'b1111, data A0..A3
//     -> gnt 0,1,2,3,0 on successive periods.
//     -> out_id 0,1,2,3,0; out_valid continuously 1; each out_data (A0,A1,...) held 4 cycles.
//   T3 single requester: only req[2]
//     -> gnt=4'b0100 the cycle after each cnt==0; out_id=2 every period.
//   T4 slip: locked with out_valid=1, cnt goes 1->3
//     -> err_slip pulse and locked=0 next cycle; out_valid=0.
//     -> no gnt until 8 good steps relock.
//   T5 empty slot: req=0 at cnt==0, req[1] raised at cnt==1
//     -> out_valid=0 for that period; req[1] granted at the next cnt==0; rr_ptr was not advanced.
//   T6 mid reset: rst pulsed 1 cycle while out_valid=1
//     -> all outputs 0; locked again after 8 good steps; first grant goes to requester 0.

Source files
------------

// File: rtl/phase_slot_arbiter.sv
// phase_slot_arbiter: round-robin arbiter that shares one slow-domain
// transfer slot among N_REQ fast-domain requesters.
//
// Ports:
//   clk_fast  : fast clock (the only clock)
//   rst       : synchronous active-high reset
//   cnt       : phase count from the clock phase counter
//   req       : per-requester level request
//   req_data  : per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   gnt       : one-hot grant, one-cycle pulse
//   out_valid : slot holds a valid transaction
//   out_data  : granted payload, stable while out_valid
//   out_id    : index of granted requester
//   locked    : phase tracking locked
//   err_slip  : one-cycle pulse on phase slip while locked
module phase_slot_arbiter #(
    parameter  int RATIO        = 4,
    parameter  int N_REQ        = 4,
    parameter  int DATA_W       = 64,
    parameter  int LAUNCH_PHASE = 0,
    parameter  int LOCK_CYCLES  = 2 * RATIO,
    localparam int CNT_W        = $clog2(RATIO),
    localparam int ID_W         = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk_fast,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        cnt,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    locked,
    output logic                    err_slip
);

    localparam int GC_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        S_UNLOCKED,
        S_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [GC_W-1:0]     r_good;
    logic [GC_W-1:0]     w_good_nx;
    logic [CNT_W-1:0]    r_prev;
    logic                r_prev_valid;
    logic [ID_W-1:0]     r_rr_ptr;

    logic [N_REQ-1:0]    r_gnt;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_id;
    logic                r_slip;

    logic                w_step_ok;
    logic                w_slip;
    logic                w_launch;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [N_REQ-1:0]    w_gnt_nx;
    logic [DATA_W-1:0]   w_sel_data;

    // A step is good only when cnt advances by exactly one phase
    // (wrapping RATIO-1 -> 0) and both samples are in range.
    always_comb begin
        w_step_ok = 1'b0;
        if (r_prev_valid && (int'(cnt) < RATIO)) begin
            if (int'(r_prev) == RATIO - 1)
                w_step_ok = (cnt == '0);
            else
                w_step_ok = (int'(cnt) == int'(r_prev) + 1);
        end
    end

    // State register
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state      <= S_UNLOCKED;
            r_good       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_good       <= w_good_nx;
            r_prev       <= cnt;
            r_prev_valid <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        w_good_nx  = r_good;
        unique case (r_state)
            S_UNLOCKED: begin
                if (!w_step_ok) begin
                    w_good_nx = '0;
                end else if (int'(r_good) == LOCK_CYCLES - 1) begin
                    w_state_nx = S_LOCKED;
                    w_good_nx  = '0;
                end else begin
                    w_good_nx = r_good + GC_W'(1);
                end
            end
            S_LOCKED: begin
                if (!w_step_ok) begin
                    w_state_nx = S_UNLOCKED;
                    w_good_nx  = '0;
                end
            end
            default: begin
                w_state_nx = S_UNLOCKED;
                w_good_nx  = '0;
            end
        endcase
    end

    // Output logic: slip detection and rotating-priority winner search.
    // A slip on the launch phase suppresses the launch.
    always_comb begin
        w_slip   = (r_state == S_LOCKED) && !w_step_ok;
        w_launch = (r_state == S_LOCKED) && w_step_ok
                   && (int'(cnt) == LAUNCH_PHASE);
        w_found  = 1'b0;
        w_win    = '0;
        // Smallest offset after rr_ptr wins.
        for (int off = 1; off <= N_REQ; off++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && req[j]
                    && ((int'(r_rr_ptr) + off) % N_REQ == j)) begin
                    w_found = 1'b1;
                    w_win   = ID_W'(j);
                end
            end
        end
        w_gnt_nx   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_found && (w_win == ID_W'(i))) begin
                w_gnt_nx[i] = 1'b1;
                w_sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Slot registers: change only on launch, slip or reset.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_id     <= '0;
            r_slip   <= 1'b0;
            r_rr_ptr <= ID_W'(N_REQ - 1);
        end else begin
            r_gnt  <= '0;
            r_slip <= w_slip;
            if (w_slip) begin
                r_valid <= 1'b0;
            end else if (w_launch) begin
                if (w_found) begin
                    r_gnt    <= w_gnt_nx;
                    r_valid  <= 1'b1;
                    r_data   <= w_sel_data;
                    r_id     <= w_win;
                    r_rr_ptr <= w_win;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign locked    = (r_state == S_LOCKED);
    assign err_slip  = r_slip;

endmodule

// File: tb/tb_phase_slot_arbiter.sv
// tb_phase_slot_arbiter: vector table, directed corner sequences and
// random traffic against a behavioural model of the slot arbiter.
module tb_phase_slot_arbiter;

    localparam int RATIO = 4;
    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int LP    = 0;
    localparam int LOCK  = 2 * RATIO;

    logic            clk_fast = 1'b0;
    logic            rst;
    logic [1:0]      cnt;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            locked;
    logic            err_slip;

    always #5 clk_fast = ~clk_fast;

    phase_slot_arbiter #(
        .RATIO(RATIO), .N_REQ(N), .DATA_W(DW),
        .LAUNCH_PHASE(LP), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .cnt      (cnt),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .locked   (locked),
        .err_slip (err_slip)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int ph     = 0;
    logic [DW-1:0] A [N];

    // Behavioural model state
    int          m_prev;
    int          m_good;
    int          m_last;
    bit          m_locked;
    logic [3:0]  m_gnt;
    bit          m_valid;
    bit          m_slip;
    logic [63:0] m_data;
    int          m_id;

    typedef struct {
        bit         rst;
        logic [1:0] cnt;
        logic [3:0] req;
        bit         lk;
        logic [3:0] g;
        bit         v;
        int         id;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit r, int c, logic [3:0] q,
                                bit lk, logic [3:0] g, bit v, int id);
        vec_t t;
        t.rst = r; t.cnt = 2'(c); t.req = q;
        t.lk = lk; t.g = g; t.v = v; t.id = id;
        return t;
    endfunction

    function automatic int pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (((r >> k) & 4'd1) != 4'd0) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
    endtask

    task automatic model_step();
        bit wf;
        int k;
        if (rst) begin
            m_prev = -1; m_good = 0; m_last = N - 1; m_locked = 0;
            m_gnt = 0; m_valid = 0; m_slip = 0; m_data = 0; m_id = 0;
            return;
        end
        wf = (m_prev >= 0) && (m_prev < RATIO) && (int'(cnt) < RATIO)
             && (int'(cnt) == (m_prev + 1) % RATIO);
        m_gnt  = 0;
        m_slip = 0;
        if (!m_locked) begin
            if (wf) begin
                m_good++;
                if (m_good == LOCK) begin
                    m_locked = 1;
                    m_good = 0;
                end
            end else begin
                m_good = 0;
            end
        end else if (!wf) begin
            m_locked = 0; m_good = 0; m_slip = 1; m_valid = 0;
        end else if (int'(cnt) == LP) begin
            k = pick(req, m_last);
            if (k < 0) begin
                m_valid = 0;
            end else begin
                m_gnt   = 4'(1 << k);
                m_valid = 1;
                m_data  = 64'(req_data >> (k * DW));
                m_id    = k;
                m_last  = k;
            end
        end
        m_prev = int'(cnt);
    endtask

    task automatic tick();
        @(posedge clk_fast);
        model_step();
        #1;
        chk("m_gnt", 64'(gnt), 64'(m_gnt));
        chk("m_valid", 64'(out_valid), 64'(m_valid));
        chk("m_data", out_data, m_data);
        chk("m_id", 64'(out_id), 64'(m_id));
        chk("m_locked", 64'(locked), 64'(m_locked));
        chk("m_slip", 64'(err_slip), 64'(m_slip));
    endtask

    task automatic good();
        cnt = 2'(ph);
        tick();
        ph = (ph + 1) % RATIO;
    endtask

    // Advance until the cycle just applied was the launch phase.
    task automatic run_to_launch();
        for (int i = 0; i < 2 * RATIO; i++) begin
            int c;
            c = ph;
            good();
            if (c == LP) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        cnt = '0;
        req = '0;
        for (int i = 0; i < N; i++) A[i] = {8{8'(160 + i)}};
        req_data = {A[3], A[2], A[1], A[0]};

        // Lock after reset, then round robin on all four requesters
        tv.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0));
        tv.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0));
        for (int c = 0; c < 9; c++)
            tv.push_back(mk(0, c % 4, 4'hF, c == 8, 4'h0, 0, 0));
        for (int c = 1; c < 4; c++)
            tv.push_back(mk(0, c, 4'hF, 1, 4'h0, 0, 0));
        for (int p = 0; p < 5; p++)
            for (int j = 0; j < 4; j++)
                tv.push_back(mk(0, j, 4'hF, 1,
                                (j == 0) ? 4'(1 << (p % 4)) : 4'h0,
                                1, p % 4));

        foreach (tv[i]) begin
            rst = tv[i].rst;
            cnt = tv[i].cnt;
            req = tv[i].req;
            tick();
            chk("tv_locked", 64'(locked), 64'(tv[i].lk));
            chk("tv_gnt", 64'(gnt), 64'(tv[i].g));
            chk("tv_valid", 64'(out_valid), 64'(tv[i].v));
            chk("tv_id", 64'(out_id), 64'(tv[i].id));
            if (tv[i].v) chk("tv_data", out_data, A[tv[i].id]);
        end
        ph = 0;

        // Single requester
        req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            int c;
            c = ph;
            good();
            if (c == LP) begin
                chk("t3_gnt", 64'(gnt), 64'h4);
                chk("t3_id", 64'(out_id), 64'd2);
            end else begin
                chk("t3_gnt_idle", 64'(gnt), 64'h0);
            end
        end

        // Empty slot, late request, pointer kept across empty launches
        req = 4'b0000;
        run_to_launch();
        chk("t5_empty", 64'(out_valid), 64'd0);
        req = 4'b0010;
        run_to_launch();
        chk("t5_gnt1", 64'(gnt), 64'h2);
        chk("t5_id1", 64'(out_id), 64'd1);
        req = 4'b1111;
        run_to_launch();
        chk("t5_next", 64'(gnt), 64'h4);
        req = 4'b0000;
        run_to_launch();
        chk("t5_empty2", 64'(out_valid), 64'd0);
        chk("t5_id_hold", 64'(out_id), 64'd2);
        req = 4'b1111;
        run_to_launch();
        chk("t5_rr_kept", 64'(gnt), 64'h8);

        // Slip 1 -> 3 while valid
        good();
        cnt = 2'd3;
        tick();
        ph = 0;
        chk("t4_slip", 64'(err_slip), 64'd1);
        chk("t4_unlock", 64'(locked), 64'd0);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_id_hold", 64'(out_id), 64'd3);
        good();
        chk("t4_slip_pulse", 64'(err_slip), 64'd0);
        for (int i = 0; i < 6; i++) begin
            good();
            chk("t4_nolock", 64'(locked), 64'd0);
            chk("t4_nognt", 64'(gnt), 64'h0);
        end
        good();
        chk("t4_relock", 64'(locked), 64'd1);
        chk("t4_nognt8", 64'(gnt), 64'h0);
        run_to_launch();
        chk("t4_gnt_after", 64'(gnt), 64'h1);

        // Reset mid-operation
        rst = 1'b1;
        good();
        rst = 1'b0;
        chk("t6_gnt", 64'(gnt), 64'h0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_data", out_data, 64'h0);
        chk("t6_id", 64'(out_id), 64'd0);
        chk("t6_locked", 64'(locked), 64'd0);
        chk("t6_slip", 64'(err_slip), 64'd0);
        for (int i = 0; i < 8; i++) begin
            good();
            chk("t6_nolock", 64'(locked), 64'd0);
        end
        good();
        chk("t6_relock", 64'(locked), 64'd1);
        run_to_launch();
        chk("t6_first", 64'(gnt), 64'h1);

        // Random traffic with occasional slips and resets
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) cnt = 2'($urandom_range(0, 3));
            else cnt = 2'(ph);
            tick();
            ph = (int'(cnt) + 1) % RATIO;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
